serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences the team's single-bit `fa_sch` full-adder cell over a WIDTH-bit operand pair, one bit per clock. It sits directly around the full adder:
- Upstream: it drives X, Y and Cprev from operand shift registers and a carry register.
- Downstream: it collects RES into a result register and feeds Cnext back as the next carry.

It gives the rest of the datapath a start/done word-level adder at one full-adder cell's cost.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request an add; sampled only in IDLE.
- A  input  WIDTH  operand A, captured on the accepting edge.
- B  input  WIDTH  operand B, captured on the accepting edge.
- CIN  input  1  carry-in, captured on the accepting edge.
- BUSY  output  1  high while in SHIFT.
- DONE  output  1  one-cycle pulse; result valid.
- SUM  output  WIDTH  result register.
- COUT  output  1  final carry-out.
- OVF  output  1  signed overflow (only with SERIAL_ADD_OVF_EN).

## Operation
- States:
  - IDLE: waits for a request.
  - SHIFT: one bit per cycle, LSB first.
  - FIN: asserts DONE.
- Reset (asynchronous, any state): state returns to IDLE. Shift registers, carry, bit counter, SUM, COUT, OVF, BUSY and DONE all go to 0.
- IDLE, START=1 at an edge:
  - Load A and B into the shift registers.
  - Load carry from CIN.
  - Clear the counter and the result register.
  - Go to SHIFT.
- IDLE, START=0: hold. SUM and COUT keep the last result.
- Each SHIFT edge:
  - `fa_sch` inputs: X = A-shift LSB, Y = B-shift LSB, Cprev = carry.
  - Result register shifts right with RES entering at the MSB.
  - Operand registers shift right.
  - carry <= Cnext; counter increments.
- After counter reaches WIDTH-1 and that edge executes: go to FIN. Exactly WIDTH SHIFT edges occur.
- FIN: DONE=1; COUT = carry. The next edge goes unconditionally to IDLE.
- START in SHIFT or FIN is ignored. It is not queued. A, B and CIN changes outside the accepting edge have no effect.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1).
- SUM is partial during SHIFT. It is defined only from FIN until the next accepting edge.

## Timing
- Edge 0 accepts START.
- BUSY is high for exactly WIDTH cycles (edges 0..WIDTH).
- DONE is high for the cycle following edge WIDTH. For WIDTH=8, DONE appears 8 edges after acceptance.
- Minimum START-to-START spacing: WIDTH+2 edges. The earliest re-accept is the edge after FIN.
- BUSY and DONE are registered (state-decoded flops). There are no combinational paths from inputs to outputs.
- Reset mid-SHIFT aborts with no DONE. The first edge after reset release can accept START.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - OVF port exists.
  - On the final SHIFT edge, ovf <= Cnext XOR carry (carry into MSB XOR carry out of MSB).
  - Held until the next accepting edge, which clears it; reset value 0.
- Not defined: no OVF port and no ovf flop; all other behaviour identical.

## Structure
- Package serial_add_pkg holds:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, FIN=2'd2);
  - default WIDTH;
  - counter-width constant $clog2(WIDTH).
- One sub-module: `fa_sch`, instantiated once as the bit-slice adder. The controller contains no other adder logic.

## Test plan
- WIDTH=8, A=0x35, B=0x4A, CIN=0, START pulse -> BUSY for 8 cycles, then DONE 1 cycle; SUM=0x7F, COUT=0, OVF=0.
- A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0; A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1, OVF=0.
- A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0, OVF=1 (with macro); no OVF port without macro.
- START held high continuously and A/B changed mid-SHIFT -> only the first operands are summed; DONE every 10 edges. SUM holds between ops until acceptance.
- RST asserted at SHIFT bit 4 -> all outputs 0 immediately, no DONE. Next START with A=0x10, B=0x20 -> SUM=0x30.
- Exhaustive WIDTH=4 sweep over A, B and CIN (512 cases) against a reference sum -> zero mismatches.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  // Counter only has to reach w-1, so $clog2(w) bits are enough (min 1).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_sch.sv
// Single-bit full-adder cell used as the bit slice of the serial adder.
module fa_sch (
  input  logic x,
  input  logic y,
  input  logic cprev,
  output logic res,
  output logic cnext
);

  assign res   = x ^ y ^ cprev;
  assign cnext = (x & y) | (cprev & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one fa_sch over WIDTH bits, LSB first.
// Optional signed-overflow flag when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             res;
  logic             cnext;

  fa_sch u_fa (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .cprev (carry),
    .res   (res),
    .cnext (cnext)
  );

  // The last SHIFT edge is the one that sees cnt == WIDTH-1; carry still
  // holds the carry into the MSB there, cnext is the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= {res, sum[WIDTH-1:1]};
          carry <= cnext;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= cnext;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= cnext ^ carry;
`endif
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 vectors and corner cases,
// plus an exhaustive WIDTH=4 sweep. Honours SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drives one request at a falling edge and returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               input logic vc);
    @(negedge clk);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int   busyCnt;
    int   doneCnt;
    int   doneAt;
    logic [7:0] capSum;
    logic capCout;
    logic capOvf;
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    capSum  = '0;
    capCout = 1'b0;
    capOvf  = 1'b0;
    applyStimulus(v.a, v.b, v.cin);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        doneAt  = j;
        capSum  = sum;
        capCout = cout;
`ifdef SERIAL_ADD_OVF_EN
        capOvf  = ovf;
`endif
      end
    end
    checkOutput({tag, "_busycycles"}, busyCnt, 8);
    checkOutput({tag, "_donecount"}, doneCnt, 1);
    checkOutput({tag, "_doneat"}, doneAt, 8);
    checkOutput({tag, "_sum"}, capSum, v.sum);
    checkOutput({tag, "_cout"}, capCout, v.cout);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput({tag, "_ovf"}, capOvf, v.ovf);
`endif
    @(negedge clk);
    checkOutput({tag, "_sumhold"}, sum, v.sum);
  endtask

  initial begin
    logic [4:0] ref4;
    logic       seen;
    vecs[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, sum: 8'h7F, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'hA5, b: 8'h3C, cin: 1'b1, sum: 8'hE2, cout: 1'b0, ovf: 1'b0};

    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      runVector(vecs[i], $sformatf("vec%0d", i));

    // START held high, operands changed while shifting.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h01; b = 8'h02;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("hold_done_k%0d", k), done, (k == 8 || k == 18) ? 1 : 0);
      if (k == 8 || k == 9) checkOutput($sformatf("hold_sum_k%0d", k), sum, 8'h7F);
      if (k == 10) begin a = 8'hAA; b = 8'h55; end
      if (k == 18) checkOutput("hold_sum2", sum, 8'h03);
      if (k == 19) start = 1'b0;
    end

    // Reset in the middle of shifting aborts the add.
    applyStimulus(8'hFF, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("midrst_nodone", seen, 0);
    runVector('{a: 8'h10, b: 8'h20, cin: 1'b0, sum: 8'h30, cout: 1'b0, ovf: 1'b0}, "postrst");

    // Exhaustive WIDTH=4 sweep.
    for (int va = 0; va < 16; va++)
      for (int vb = 0; vb < 16; vb++)
        for (int vc = 0; vc < 2; vc++) begin
          @(negedge clk);
          a4 = 4'(va); b4 = 4'(vb); cin4 = 1'(vc); start4 = 1'b1;
          @(posedge clk);
          #1 start4 = 1'b0;
          seen = 1'b0;
          for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
          end
          ref4 = 5'(va + vb + vc);
          if (!seen)
            checkOutput($sformatf("w4_timeout a=%0h b=%0h c=%0d", va, vb, vc), 0, 1);
          else begin
            checkOutput($sformatf("w4_sum a=%0h b=%0h c=%0d", va, vb, vc),
                        {cout4, sum4}, ref4);
`ifdef SERIAL_ADD_OVF_EN
            checkOutput($sformatf("w4_ovf a=%0h b=%0h c=%0d", va, vb, vc), ovf4,
                        (a4[3] == b4[3]) && (ref4[3] != a4[3]));
`endif
          end
          @(negedge clk);
        end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
